heichips25_adder_arbiter: RTL and testbench

// - Shares one registered W-bit adder among N requesters using round-robin arbitration.
// - Each requester offers an operand pair (a, b) on a valid/ready handshake.
// - The block returns {sum, carry} tagged with the requester index on a single response channel.
// - Sits between the user-project I/O front end and the shared add datapath.

---
 rtl/heichips25_adder_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_heichips25_adder_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heichips25_adder_arbiter.sv
// ---------------------------------------------------------------------------
// heichips25_adder_arbiter
//
// Shares one registered W-bit adder among N requesters. Requesters are served
// round-robin over a valid/ready handshake. Each result {sum, carry} is
// returned on a single response channel, tagged with the index of the
// requester it belongs to.
//
// Transaction flow: IDLE (grant + latch operands) -> CALC (register the add)
// -> RESP (hold the result until the consumer accepts it) -> IDLE.
//
// Parameters:
//   N  number of requesters (1..8)
//   W  operand / sum width in bits
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  [N]    requester i presents operands
//   req_ready  [N]    grant, one-hot or zero, combinational, IDLE only
//   req_a      [N*W]  operand a, requester i on bits [i*W +: W]
//   req_b      [N*W]  operand b, same packing as req_a
//   rsp_valid         response available
//   rsp_ready         consumer accepts the response
//   rsp_id     [IW]   index of the served requester
//   rsp_sum    [W]    result
//   rsp_carry         carry-out of the W-bit add
//
// Configuration:
//   HEICHIPS25_ADDER_ARB_SAT_EN  when defined, rsp_sum saturates to all-ones
//                                on carry (rsp_carry still reports the
//                                overflow); otherwise rsp_sum wraps mod 2^W.
// ---------------------------------------------------------------------------
module heichips25_adder_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q,     state_d;
  logic [IW-1:0] rr_ptr_q,    rr_ptr_d;
  logic [W-1:0]  a_q,         a_d;
  logic [W-1:0]  b_q,         b_d;
  logic [IW-1:0] id_q,        id_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q,    rsp_id_d;
  logic [W-1:0]  rsp_sum_q,   rsp_sum_d;
  logic          rsp_carry_q, rsp_carry_d;

  logic          grant_found;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] grant_next_ptr;
  logic [W:0]    sum_full;
  logic [W-1:0]  sum_out;

  // Round-robin scan starting at rr_ptr; the first requester found wins.
  // NOTE: every variable written in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  // Pointer moves just past the grantee; with N=1 this is always 0.
  assign grant_next_ptr = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;

  // Grant is visible only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Add at W+1 bits so the carry falls out of the top bit.
  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

`ifdef HEICHIPS25_ADDER_ARB_SAT_EN
  assign sum_out = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum_out = sum_full[W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;

    case (state_q)
      IDLE: begin
        // The grantee's valid is set by construction, so a grant is a
        // completed handshake.
        if (grant_found) begin
          a_d      = req_a[int'(grant_id)*W +: W];
          b_d      = req_b[int'(grant_id)*W +: W];
          id_d     = grant_id;
          rr_ptr_d = grant_next_ptr;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = sum_out;
        rsp_carry_d = sum_full[W];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_heichips25_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_heichips25_adder_arbiter
//
// Directed bench for heichips25_adder_arbiter with N=4, W=8. Inputs change
// and outputs are observed on the falling edge, half a cycle away from the
// rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_heichips25_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;

  int n_checks = 0;
  int n_fail   = 0;

  heichips25_adder_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction from requester g with rsp_ready held high; caller sits
  // at a falling edge with the arbiter in IDLE and pointer selecting g.
  task automatic drive_txn(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_sum, input logic exp_carry,
                           input string name);
    req_valid       = N'(1 << g);
    req_a[g*W +: W] = a;
    req_b[g*W +: W] = b;
    rsp_ready       = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== N'(1 << g)) begin
      n_fail++;
      $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, N'(1 << g));
    end
    next_cycle();
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL %s calc: rsp_valid=%b req_ready=%b expected 0 and 0000", name, rsp_valid, req_ready);
    end
    next_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== IW'(g) || rsp_sum !== exp_sum || rsp_carry !== exp_carry) begin
      n_fail++;
      $display("FAIL %s resp: valid=%b id=%0d sum=%h carry=%b expected 1 %0d %h %b",
               name, rsp_valid, rsp_id, rsp_sum, rsp_carry, g, exp_sum, exp_carry);
    end
    next_cycle();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: rsp_valid=%b expected 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready);
    end
    next_cycle();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== '0 || rsp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b id=%0d sum=%h carry=%b expected all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_carry);
    end
    req_valid = '0;
    rst       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL idle_%0d: rsp_valid=%b req_ready=%b expected 0 and 0000", i, rsp_valid, req_ready);
      end
    end
  endtask

  // Pointer is still 0 after the idle stretch, so order starts at 0.
  task automatic test_all_requesting();
    logic [W-1:0] exp_sum [N];
    exp_sum = '{8'h03, 8'h14, 8'h25, 8'h36};
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(8'h10 * i + 1);
      req_b[i*W +: W] = W'(i + 2);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      n_checks++;
      if (req_ready !== N'(1 << (t % N))) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: req_ready=%b expected %b", t, req_ready, N'(1 << (t % N)));
      end
      next_cycle();
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL rr_calc_%0d: rsp_valid=%b req_ready=%b expected 0 and 0000", t, rsp_valid, req_ready);
      end
      next_cycle();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IW'(t % N) || rsp_sum !== exp_sum[t % N] || rsp_carry !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_resp_%0d: valid=%b id=%0d sum=%h carry=%b expected 1 %0d %h 0",
                 t, rsp_valid, rsp_id, rsp_sum, rsp_carry, t % N, exp_sum[t % N]);
      end
      next_cycle();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_single_cycle_%0d: rsp_valid=%b expected 0", t, rsp_valid);
      end
    end
    req_valid = '0;
  endtask

  // Pointer is 1 here; scan 1 -> 2 picks requester 2.
  task automatic test_single_request();
    drive_txn(2, 8'h12, 8'h34, 8'h46, 1'b0, "single_req2");
  endtask

  // Pointer is 3; only requester 1 asks. Requester 0 asks during RESP and
  // must not be granted until the response is taken.
  task automatic test_back_pressure();
    req_valid       = 4'b0010;
    req_a[1*W +: W] = 8'h20;
    req_b[1*W +: W] = 8'h05;
    rsp_ready       = 1'b0;
    next_cycle();
    req_valid = '0;
    next_cycle();
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h25 || rsp_carry !== 1'b0 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b id=%0d sum=%h carry=%b ready=%b expected 1 1 25 0 0000",
                 i, rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready);
      end
      if (i < 4) next_cycle();
    end
    rsp_ready = 1'b1;
    next_cycle();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0 and 0001", rsp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  // Pointer is 2: requester 3 first, then pointer 0 serves requester 0.
  task automatic test_overflow();
`ifdef HEICHIPS25_ADDER_ARB_SAT_EN
    drive_txn(3, 8'hFF, 8'h02, 8'hFF, 1'b1, "ovf_ff_02");
    drive_txn(0, 8'hFF, 8'hFF, 8'hFF, 1'b1, "ovf_ff_ff");
`else
    drive_txn(3, 8'hFF, 8'h02, 8'h01, 1'b1, "ovf_ff_02");
    drive_txn(0, 8'hFF, 8'hFF, 8'hFE, 1'b1, "ovf_ff_ff");
`endif
  endtask

  task automatic test_reset_in_flight();
    // Reset during CALC: the add never reaches the response channel.
    req_valid       = 4'b1000;
    req_a[3*W +: W] = 8'h01;
    req_b[3*W +: W] = 8'h01;
    rsp_ready       = 1'b0;
    next_cycle();
    req_valid = '0;
    rst       = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_calc_%0d: rsp_valid=%b expected 0", i, rsp_valid);
      end
    end
    // Reset during RESP: response withdrawn, pointer back to 0.
    req_valid = 4'b1000;
    next_cycle();
    req_valid = '0;
    next_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h02) begin
      n_fail++;
      $display("FAIL rst_resp_pre: rsp_valid=%b sum=%h expected 1 02", rsp_valid, rsp_sum);
    end
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL rst_resp_ready: req_ready=%b expected 0000", req_ready);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0) begin
      n_fail++;
      $display("FAIL rst_resp_clear: valid=%b sum=%h id=%0d expected 0 00 0", rsp_valid, rsp_sum, rsp_id);
    end
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_resp_regrant: req_ready=%b expected 0010", req_ready);
    end
    req_valid = '0;
    next_cycle();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_all_requesting();
    test_single_request();
    test_back_pressure();
    test_overflow();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
